// File: rtl/cache_arb_pkg.sv
// ----------------------------------------------------------------------------
// cache_arb_pkg
//   Shared definitions for the cache lookup port arbiter and the cache it
//   drives: arbiter FSM state encoding, default lookup address/data widths,
//   and a small modulo-increment helper used for the round-robin pointer.
// ----------------------------------------------------------------------------
package cache_arb_pkg;

   // Widths agreed with the cache so both sides default to the same bus shape
   localparam int CACHE_ADDR_W = 32;
   localparam int CACHE_DATA_W = 64;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESPOND
   } arb_state_t;

   // value + 1, wrapping back to 0 when it reaches modulus
   function automatic int wrap_inc(input int value, input int modulus);
      return (value + 1 >= modulus) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Starting at rr_ptr and searching
//   upward (wrapping at NUM_REQ), returns the first requester with req set.
//
// Ports
//   req        in   NUM_REQ   request vector
//   rr_ptr     in   IDX_W     index with highest priority this round
//   grant      out  NUM_REQ   one-hot of the selected requester (0 if none)
//   grant_idx  out  IDX_W     binary index of the selected requester
//   any_valid  out  1         at least one request was present
// ----------------------------------------------------------------------------
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_valid
);

   // Walk the candidates in priority order; the first hit freezes the result
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!any_valid && req[cand_idx]) begin
            any_valid       = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
//   Shares the single cache lookup port among NUM_REQ requesters (fetch and
//   load/store front ends). Round-robin grant, one lookup in flight, and a
//   one-cycle response pulse routed back to the requester that was granted.
//   A lookup that never completes is closed after TIMEOUT wait cycles as a
//   forced miss with rsp_err set.
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   req_valid  [N]      requester i holds high with stable address until ready
//   req_addr   [N*A]    requester i address in slice [i*ADDR_W +: ADDR_W]
//   req_ready  [N]      one-hot accept pulse
//   rsp_valid  [N]      one-hot response pulse
//   rsp_hit/err/data    response payload, valid with rsp_valid
//   cache_search        one-cycle lookup start pulse
//   cache_address       lookup address, held from issue through response
//   cache_hit           may pulse any time before cache_search_done
//   cache_search_done   lookup complete pulse
//   cache_data          sampled in the cache_search_done cycle
// ----------------------------------------------------------------------------
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = CACHE_ADDR_W,
   parameter int DATA_W  = CACHE_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_hit,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      cache_search,
   output logic [ADDR_W-1:0]         cache_address,
   input  logic                      cache_hit,
   input  logic                      cache_search_done,
   input  logic [DATA_W-1:0]         cache_data
);

   localparam int               IDX_W     = $clog2(NUM_REQ);
   localparam int               CNT_W     = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                sticky_q, sticky_d;
   logic [CNT_W-1:0]    wait_q, wait_d;
   logic [NUM_REQ-1:0]  ready_d;
   logic [NUM_REQ-1:0]  rsp_valid_d;
   logic                rsp_hit_d;
   logic                rsp_err_d;
   logic [DATA_W-1:0]   rsp_data_d;
   logic                search_d;
   logic [ADDR_W-1:0]   address_d;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [ADDR_W-1:0]   addr_slot [NUM_REQ];

   // Split the flat address bus into one slot per requester
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_slot[i] = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   // Next-state and next-output logic. All outputs are registered, so each
   // pulse here appears on the port one cycle after the state that makes it:
   // req_ready shows during ISSUE, cache_search during the first WAIT cycle,
   // rsp_valid during RESPOND. The sticky hit catches a hit pulse that ends
   // before search_done; it is folded with the live hit in the done cycle.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      sticky_d    = sticky_q;
      wait_d      = wait_q;
      address_d   = cache_address;
      ready_d     = '0;
      rsp_valid_d = '0;
      rsp_hit_d   = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = '0;
      search_d    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d   = pick_idx;
               address_d = addr_slot[pick_idx];
               ready_d   = pick_grant;
               state_d   = ARB_ISSUE;
            end
         end

         ARB_ISSUE: begin
            search_d = 1'b1;
            sticky_d = 1'b0;
            wait_d   = '0;
            state_d  = ARB_WAIT;
         end

         ARB_WAIT: begin
            // Completion is tested first so it wins over a same-cycle timeout
            if (cache_search_done) begin
               rsp_valid_d[grant_q] = 1'b1;
               rsp_hit_d            = sticky_q | cache_hit;
               rsp_data_d           = cache_data;
               state_d              = ARB_RESPOND;
            end else if (wait_q == WAIT_LAST) begin
               rsp_valid_d[grant_q] = 1'b1;
               rsp_err_d            = 1'b1;
               state_d              = ARB_RESPOND;
            end else begin
               sticky_d = sticky_q | cache_hit;
               wait_d   = wait_q + CNT_W'(1);
            end
         end

         ARB_RESPOND: begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));
            state_d  = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers; reset aborts any lookup in flight with no
   // response, since the cache is reset by the same source
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         sticky_q      <= 1'b0;
         wait_q        <= '0;
         req_ready     <= '0;
         rsp_valid     <= '0;
         rsp_hit       <= 1'b0;
         rsp_err       <= 1'b0;
         rsp_data      <= '0;
         cache_search  <= 1'b0;
         cache_address <= '0;
      end else begin
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         sticky_q      <= sticky_d;
         wait_q        <= wait_d;
         req_ready     <= ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_hit       <= rsp_hit_d;
         rsp_err       <= rsp_err_d;
         rsp_data      <= rsp_data_d;
         cache_search  <= search_d;
         cache_address <= address_d;
      end
   end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_port_arbiter
//   Self-checking bench for cache_port_arbiter. The bench plays both the
//   requesters and the cache; a transaction-level model (round-robin pointer,
//   per-requester valid/address arrays) predicts grants and responses.
// ----------------------------------------------------------------------------
module tb_cache_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int TO = 16;

   logic              clock;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic              rsp_hit;
   logic              rsp_err;
   logic [DW-1:0]     rsp_data;
   logic              cache_search;
   logic [AW-1:0]     cache_address;
   logic              cache_hit;
   logic              cache_search_done;
   logic [DW-1:0]     cache_data;

   int                checks;
   int                errors;
   int                model_ptr;
   logic              valid_m [N];
   logic [AW-1:0]     addr_m [N];
   bit                autoUpdate;

   cache_port_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_addr          (req_addr),
      .req_ready         (req_ready),
      .rsp_valid         (rsp_valid),
      .rsp_hit           (rsp_hit),
      .rsp_err           (rsp_err),
      .rsp_data          (rsp_data),
      .cache_search      (cache_search),
      .cache_address     (cache_address),
      .cache_hit         (cache_hit),
      .cache_search_done (cache_search_done),
      .cache_data        (cache_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run always ends even if the design locks up
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed=no finish required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic driveReqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = valid_m[i];
         req_addr[i*AW +: AW]   = addr_m[i];
      end
   endtask

   // First valid requester at or after the model pointer, wrapping around
   function automatic int expectedGrant();
      for (int i = 0; i < N; i++) begin
         if (valid_m[(model_ptr + i) % N]) return (model_ptr + i) % N;
      end
      return 0;
   endfunction

   // After a grant: the winner either re-requests a new address or drops;
   // idle requesters may join; at least one request is always left pending
   task automatic requesterUpdate(input int g);
      bit any;
      any = 1'b0;
      if ($urandom_range(3) != 0) addr_m[g] = $urandom;
      else                        valid_m[g] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i != g && !valid_m[i] && $urandom_range(1) == 1) begin
            valid_m[i] = 1'b1;
            addr_m[i]  = $urandom;
         end
      end
      for (int i = 0; i < N; i++) if (valid_m[i]) any = 1'b1;
      if (!any) begin
         int j;
         j          = $urandom_range(N - 1);
         valid_m[j] = 1'b1;
         addr_m[j]  = $urandom;
      end
      driveReqs();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req_ready"},     req_ready,     '0);
      checkOutput({tag, "_rsp_valid"},     rsp_valid,     '0);
      checkOutput({tag, "_rsp_hit"},       rsp_hit,       '0);
      checkOutput({tag, "_rsp_err"},       rsp_err,       '0);
      checkOutput({tag, "_rsp_data"},      rsp_data,      '0);
      checkOutput({tag, "_cache_search"},  cache_search,  '0);
      checkOutput({tag, "_cache_address"}, cache_address, '0);
   endtask

   // Called at a negedge whose following posedge sees the arbiter idle
   task automatic applyReset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      model_ptr = 0;
      reset     = 1'b0;
   endtask

   // One complete transaction, entered at a negedge whose following posedge
   // sees the arbiter idle. lookup = WAIT cycle carrying search_done (1..TO),
   // or 0 for a lookup that never completes. hitCycle = WAIT cycle carrying
   // a hit pulse (0 = none). spurious adds hit/done pulses outside WAIT.
   task automatic applyStimulus(input int lookup, input int hitCycle, input bit spurious);
      int            g;
      int            lastWait;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expData;
      logic          expHit;
      g        = expectedGrant();
      expAddr  = addr_m[g];
      expData  = '0;
      expHit   = 1'b0;
      lastWait = (lookup == 0) ? TO : lookup;

      @(negedge clock);
      checkOutput("req_ready", req_ready, onehot(g));
      if (spurious) cache_hit = 1'b1;
      if (autoUpdate) requesterUpdate(g);

      for (int k = 1; k <= lastWait + 1; k++) begin
         @(negedge clock);
         if (k == 1) begin
            checkOutput("cache_search", cache_search, 1'b1);
            checkOutput("cache_address", cache_address, expAddr);
         end
         if (k == 2) checkOutput("search_pulse", cache_search, 1'b0);
         if (k <= lastWait) begin
            if (k == lastWait) checkOutput("rsp_early", rsp_valid, '0);
            cache_hit         = (k == hitCycle);
            cache_search_done = (k == lookup);
            cache_data        = {$urandom, $urandom};
            if (k == lookup) expData = cache_data;
            if (lookup != 0 && k == hitCycle) expHit = 1'b1;
         end else begin
            checkOutput("rsp_valid", rsp_valid, onehot(g));
            checkOutput("rsp_hit", rsp_hit, expHit);
            checkOutput("rsp_err", rsp_err, (lookup == 0));
            checkOutput("rsp_data", rsp_data, expData);
            checkOutput("address_hold", cache_address, expAddr);
            cache_hit         = spurious;
            cache_search_done = spurious;
            cache_data        = {$urandom, $urandom};
            model_ptr         = (g + 1) % N;
         end
      end

      @(negedge clock);
      checkOutput("rsp_pulse", rsp_valid, '0);
      cache_hit         = 1'b0;
      cache_search_done = 1'b0;
   endtask

   initial begin
      int lookup;
      int hitCycle;
      int lastWait;
      int g;

      checks            = 0;
      errors            = 0;
      model_ptr         = 0;
      autoUpdate        = 1'b0;
      reset             = 1'b1;
      req_valid         = '0;
      req_addr          = '0;
      cache_hit         = 1'b0;
      cache_search_done = 1'b0;
      cache_data        = '0;
      for (int i = 0; i < N; i++) begin
         valid_m[i] = 1'b0;
         addr_m[i]  = '0;
      end

      // Reset state
      repeat (3) @(negedge clock);
      checkAllZero("reset");

      // Single request from requester 0, lookup finishing with a hit
      valid_m[0] = 1'b1;
      addr_m[0]  = 32'h0000_0010;
      driveReqs();
      reset = 1'b0;
      applyStimulus(2, 2, 1'b0);

      // Requesters 0 and 1 held continuously from reset: grants alternate
      valid_m[1] = 1'b1;
      addr_m[0]  = $urandom;
      addr_m[1]  = $urandom;
      driveReqs();
      applyReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom_range(4, 1), $urandom_range(3, 0), 1'b0);
      end

      // Hit pulse early in WAIT, gone before done: must still report a hit
      applyStimulus(4, 1, 1'b0);

      // No completion: forced miss with error, then the next grant proceeds
      applyStimulus(0, 3, 1'b1);
      applyStimulus(1, 1, 1'b0);

      // Completion on the timeout cycle: completion wins
      applyStimulus(TO, 0, 1'b0);

      // Reset during WAIT: abort with no response, pointer back to 0
      if (model_ptr != 1) applyStimulus(1, 0, 1'b0);
      g = expectedGrant();
      @(negedge clock);
      checkOutput("abort_req_ready", req_ready, onehot(g));
      @(negedge clock);
      checkOutput("abort_search", cache_search, 1'b1);
      @(negedge clock);
      cache_hit = 1'b1;
      reset     = 1'b1;
      @(negedge clock);
      checkAllZero("abort");
      cache_hit = 1'b0;
      reset     = 1'b0;
      model_ptr = 0;
      applyStimulus(2, 0, 1'b0);

      // Randomized traffic with requesters joining and leaving
      autoUpdate = 1'b1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(9))
            0:       lookup = 0;
            1:       lookup = TO;
            default: lookup = $urandom_range(TO - 1, 1);
         endcase
         lastWait = (lookup == 0) ? TO : lookup;
         hitCycle = ($urandom_range(2) == 0) ? 0 : $urandom_range(lastWait, 1);
         applyStimulus(lookup, hitCycle, ($urandom_range(1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
